wb_multi_counter: RTL and testbench

Parametrised multi-channel counter/timer for the user project area, controlled from the management SoC over Wishbone.
- Each channel counts up or down toward a programmable limit, in one-shot or periodic mode.
- Each channel raises a sticky match flag, maskable into a combined interrupt.
- Logic-analyzer inputs can freeze all counting and force-load channel 0; channel 0's count drives the IO pads.

---
 rtl/wb_multi_counter_pkg.sv | 17 +
 rtl/counter_channel.sv | 124 ++++++++++++
 rtl/wb_multi_counter.sv | 130 +++++++++++++
 tb/tb_wb_multi_counter.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_multi_counter_pkg.sv
// wb_multi_counter_pkg
//   Shared definitions for the Wishbone multi-channel counter:
//   per-channel register offsets (word index taken from adr[3:2]) and
//   the bit positions inside the CTRL register.
package wb_multi_counter_pkg;

  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_COUNT  = 2'd1;
  localparam logic [1:0] REG_LIMIT  = 2'd2;
  localparam logic [1:0] REG_STATUS = 2'd3;

  localparam int CTRL_EN       = 0;
  localparam int CTRL_DOWN     = 1;
  localparam int CTRL_PERIODIC = 2;
  localparam int CTRL_IRQEN    = 3;

endpackage

// File: rtl/counter_channel.sv
// counter_channel
//   One counter/timer channel: CTRL, COUNT, LIMIT and STATUS registers,
//   the per-cycle count step and the match logic.
// Ports:
//   clk, reset           clock, synchronous active-high reset
//   freeze               blocks count steps and match events
//   wr_ctrl/count/limit  one-cycle write strobes for this channel's registers
//   wr_status            one-cycle STATUS write strobe (write-1-to-clear)
//   wr_data, wr_sel      Wishbone write data and byte-lane selects
//   load_en, load_val    external force-load of COUNT (lower priority than WB)
//   ctrl_o .. status_o   current register contents for the read mux / irq
//   match_o              one-cycle pulse the cycle after a match event
module counter_channel
  import wb_multi_counter_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             freeze,
  input  logic             wr_ctrl,
  input  logic             wr_count,
  input  logic             wr_limit,
  input  logic             wr_status,
  input  logic [31:0]      wr_data,
  input  logic [3:0]       wr_sel,
  input  logic             load_en,
  input  logic [WIDTH-1:0] load_val,
  output logic [3:0]       ctrl_o,
  output logic [WIDTH-1:0] count_o,
  output logic [WIDTH-1:0] limit_o,
  output logic             status_o,
  output logic             match_o
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] limit_q, limit_d;
  logic [3:0]       ctrl_q, ctrl_d;
  logic             status_q, status_d;
  logic             match_q, match_d;

  // Byte-lane merged write values; bits above WIDTH simply do not exist.
  logic [WIDTH-1:0] count_wr;
  logic [WIDTH-1:0] limit_wr;

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_lane
      assign count_wr[gi] = wr_sel[gi / 8] ? wr_data[gi] : count_q[gi];
      assign limit_wr[gi] = wr_sel[gi / 8] ? wr_data[gi] : limit_q[gi];
    end
  endgenerate

  // Upper data bits / lanes are unused for narrow WIDTH.
  logic unused_wr;
  assign unused_wr = &{1'b0, wr_data, wr_sel};

  logic step;
  logic hit;
  logic match_event;

  always_comb begin
    step        = ctrl_q[CTRL_EN] & ~freeze;
    hit         = ctrl_q[CTRL_DOWN] ? (count_q == '0) : (count_q == limit_q);
    match_event = step & hit;

    count_d  = count_q;
    limit_d  = limit_q;
    ctrl_d   = ctrl_q;
    status_d = status_q;
    match_d  = match_event;

    if (step) begin
      if (hit) begin
        if (ctrl_q[CTRL_PERIODIC]) begin
          count_d = ctrl_q[CTRL_DOWN] ? limit_q : '0;
        end else begin
          // one-shot: hold the count and stop
          ctrl_d[CTRL_EN] = 1'b0;
        end
      end else begin
        count_d = ctrl_q[CTRL_DOWN] ? (count_q - ONE) : (count_q + ONE);
      end
    end

    // COUNT priority: WB write > external load > count step
    if (load_en) count_d = load_val;
    if (wr_count) count_d = count_wr;

    if (wr_limit) limit_d = limit_wr;

    // A CTRL write overrides the one-shot auto-clear of en.
    if (wr_ctrl && wr_sel[0]) ctrl_d = wr_data[3:0];

    // A new match beats a simultaneous write-1-to-clear.
    if (wr_status && wr_sel[0] && wr_data[0]) status_d = 1'b0;
    if (match_event) status_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q  <= '0;
      limit_q  <= '0;
      ctrl_q   <= '0;
      status_q <= 1'b0;
      match_q  <= 1'b0;
    end else begin
      count_q  <= count_d;
      limit_q  <= limit_d;
      ctrl_q   <= ctrl_d;
      status_q <= status_d;
      match_q  <= match_d;
    end
  end

  assign ctrl_o   = ctrl_q;
  assign count_o  = count_q;
  assign limit_o  = limit_q;
  assign status_o = status_q;
  assign match_o  = match_q;

endmodule

// File: rtl/wb_multi_counter.sv
// wb_multi_counter
//   Multi-channel up/down counter/timer behind a Wishbone slave port.
//   Channel = adr[7:4], register = adr[3:2] (CTRL, COUNT, LIMIT, STATUS).
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   wbs_*             Wishbone slave (registered ack, 1-cycle latency)
//   la_freeze         stops all counting and match events
//   la_load_en/_val   force-load of channel 0 COUNT
//   count0_o          channel 0 COUNT, to the IO pads
//   match_o           per-channel one-cycle match pulse
//   irq_o             OR of (STATUS.match & CTRL.irq_en), level
module wb_multi_counter
  import wb_multi_counter_pkg::*;
#(
  parameter int CHANNELS = 4,
  parameter int WIDTH    = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                wbs_cyc_i,
  input  logic                wbs_stb_i,
  input  logic                wbs_we_i,
  input  logic [3:0]          wbs_sel_i,
  input  logic [31:0]         wbs_adr_i,
  input  logic [31:0]         wbs_dat_i,
  output logic                wbs_ack_o,
  output logic [31:0]         wbs_dat_o,
  input  logic                la_freeze,
  input  logic                la_load_en,
  input  logic [WIDTH-1:0]    la_load_val,
  output logic [WIDTH-1:0]    count0_o,
  output logic [CHANNELS-1:0] match_o,
  output logic                irq_o
);

  logic        ack_q, ack_d;
  logic [31:0] dat_q, dat_d;

  logic       access;
  logic       wr_access;
  logic [3:0] ch_idx;
  logic [1:0] reg_idx;

  assign ch_idx    = wbs_adr_i[7:4];
  assign reg_idx   = wbs_adr_i[3:2];
  // The ~ack term splits held strobes into ack,idle,ack,... beats.
  assign access    = wbs_cyc_i & wbs_stb_i & ~ack_q;
  assign wr_access = access & wbs_we_i;

  logic unused_adr;
  assign unused_adr = &{1'b0, wbs_adr_i[31:8], wbs_adr_i[1:0]};

  logic [3:0]       ctrl_a  [CHANNELS];
  logic [WIDTH-1:0] count_a [CHANNELS];
  logic [WIDTH-1:0] limit_a [CHANNELS];
  logic [CHANNELS-1:0] status_v;
  logic [CHANNELS-1:0] irqen_v;
  logic [CHANNELS-1:0] match_v;

  genvar gi;
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_ch
      logic sel_ch;
      // Channels that do not exist never decode, so those writes drop.
      assign sel_ch = wr_access && (ch_idx == 4'(gi));

      counter_channel #(
        .WIDTH(WIDTH)
      ) u_channel (
        .clk      (clk),
        .reset    (reset),
        .freeze   (la_freeze),
        .wr_ctrl  (sel_ch && (reg_idx == REG_CTRL)),
        .wr_count (sel_ch && (reg_idx == REG_COUNT)),
        .wr_limit (sel_ch && (reg_idx == REG_LIMIT)),
        .wr_status(sel_ch && (reg_idx == REG_STATUS)),
        .wr_data  (wbs_dat_i),
        .wr_sel   (wbs_sel_i),
        .load_en  ((gi == 0) ? la_load_en : 1'b0),
        .load_val (la_load_val),
        .ctrl_o   (ctrl_a[gi]),
        .count_o  (count_a[gi]),
        .limit_o  (limit_a[gi]),
        .status_o (status_v[gi]),
        .match_o  (match_v[gi])
      );

      assign irqen_v[gi] = ctrl_a[gi][CTRL_IRQEN];
    end
  endgenerate

  // Read mux sees the registers before this cycle's write lands.
  logic [31:0] rdata;
  always_comb begin
    rdata = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (ch_idx == 4'(i)) begin
        case (reg_idx)
          REG_CTRL:   rdata = {28'b0, ctrl_a[i]};
          REG_COUNT:  rdata = 32'(count_a[i]);
          REG_LIMIT:  rdata = 32'(limit_a[i]);
          REG_STATUS: rdata = {31'b0, status_v[i]};
          default:    rdata = '0;
        endcase
      end
    end
  end

  always_comb begin
    ack_d = access;
    dat_d = access ? rdata : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ack_q <= 1'b0;
      dat_q <= '0;
    end else begin
      ack_q <= ack_d;
      dat_q <= dat_d;
    end
  end

  assign wbs_ack_o = ack_q;
  assign wbs_dat_o = dat_q;
  assign count0_o  = count_a[0];
  assign match_o   = match_v;
  assign irq_o     = |(status_v & irqen_v);

endmodule

// File: tb/tb_wb_multi_counter.sv
module tb_wb_multi_counter;

  logic        clk = 1'b0;
  logic        reset;
  logic        wbs_cyc_i, wbs_stb_i, wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i, wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;
  logic        la_freeze, la_load_en;
  logic [31:0] la_load_val;
  logic [31:0] count0_o;
  logic [3:0]  match_o;
  logic        irq_o;

  // Narrow-width instance sharing the bus, frozen, used for width checks.
  logic        unused_ack16;
  logic [31:0] dat16;
  logic [15:0] unused_count16;
  logic [3:0]  unused_match16;
  logic        unused_irq16;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  wb_multi_counter #(.CHANNELS(4), .WIDTH(32)) dut (
    .clk(clk), .reset(reset),
    .wbs_cyc_i(wbs_cyc_i), .wbs_stb_i(wbs_stb_i), .wbs_we_i(wbs_we_i),
    .wbs_sel_i(wbs_sel_i), .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i),
    .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o),
    .la_freeze(la_freeze), .la_load_en(la_load_en), .la_load_val(la_load_val),
    .count0_o(count0_o), .match_o(match_o), .irq_o(irq_o)
  );

  wb_multi_counter #(.CHANNELS(4), .WIDTH(16)) dut16 (
    .clk(clk), .reset(reset),
    .wbs_cyc_i(wbs_cyc_i), .wbs_stb_i(wbs_stb_i), .wbs_we_i(wbs_we_i),
    .wbs_sel_i(wbs_sel_i), .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i),
    .wbs_ack_o(unused_ack16), .wbs_dat_o(dat16),
    .la_freeze(1'b1), .la_load_en(1'b0), .la_load_val(16'h0),
    .count0_o(unused_count16), .match_o(unused_match16), .irq_o(unused_irq16)
  );

  // ---------------- reference model (4 channels, 32-bit) ----------------
  logic [31:0] m_count [4];
  logic [31:0] m_limit [4];
  logic [3:0]  m_ctrl  [4];
  logic        m_status[4];
  logic [3:0]  m_match;
  logic        m_ack;
  logic [31:0] m_rdat;

  function automatic logic [31:0] lanes(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] sel);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (sel[b]) r[b*8 +: 8] = nw[b*8 +: 8];
    return r;
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] adr);
    int ch;
    ch = int'(adr[7:4]);
    if (ch >= 4) return 32'h0;
    case (adr[3:2])
      2'd0:    return {28'h0, m_ctrl[ch]};
      2'd1:    return m_count[ch];
      2'd2:    return m_limit[ch];
      default: return {31'h0, m_status[ch]};
    endcase
  endfunction

  function automatic logic model_irq();
    logic r;
    r = 1'b0;
    for (int c = 0; c < 4; c++) if (m_status[c] && m_ctrl[c][3]) r = 1'b1;
    return r;
  endfunction

  always @(posedge clk) begin : model
    logic acc, wr, ev, nst;
    logic [31:0] nc;
    logic [3:0] nctrl;
    int ch, rg;
    if (reset) begin
      m_ack   <= 1'b0;
      m_rdat  <= 32'h0;
      m_match <= 4'h0;
      for (int c = 0; c < 4; c++) begin
        m_count[c] <= 0; m_limit[c] <= 0; m_ctrl[c] <= 0; m_status[c] <= 0;
      end
    end else begin
      acc = wbs_cyc_i && wbs_stb_i && !m_ack;
      m_ack  <= acc;
      m_rdat <= acc ? model_read(wbs_adr_i) : 32'h0;
      ch = int'(wbs_adr_i[7:4]);
      rg = int'(wbs_adr_i[3:2]);
      for (int c = 0; c < 4; c++) begin
        nc = m_count[c]; nctrl = m_ctrl[c]; nst = m_status[c]; ev = 1'b0;
        wr = acc && wbs_we_i && (ch == c);
        if (m_ctrl[c][0] && !la_freeze) begin
          if (!m_ctrl[c][1]) begin
            if (m_count[c] == m_limit[c]) begin
              ev = 1'b1;
              if (m_ctrl[c][2]) nc = 0; else nctrl[0] = 1'b0;
            end else nc = m_count[c] + 1;
          end else begin
            if (m_count[c] == 0) begin
              ev = 1'b1;
              if (m_ctrl[c][2]) nc = m_limit[c]; else nctrl[0] = 1'b0;
            end else nc = m_count[c] - 1;
          end
        end
        if (c == 0 && la_load_en) nc = la_load_val;
        if (wr && rg == 1) nc = lanes(m_count[c], wbs_dat_i, wbs_sel_i);
        if (wr && rg == 2) m_limit[c] <= lanes(m_limit[c], wbs_dat_i, wbs_sel_i);
        if (wr && rg == 0 && wbs_sel_i[0]) nctrl = wbs_dat_i[3:0];
        if (wr && rg == 3 && wbs_sel_i[0] && wbs_dat_i[0]) nst = 1'b0;
        if (ev) nst = 1'b1;
        m_count[c]  <= nc;
        m_ctrl[c]   <= nctrl;
        m_status[c] <= nst;
        m_match[c]  <= ev;
      end
    end
  end

  // ---------------- checking helpers ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // One clock, sampled 1 ns after the edge, with output-vs-model checks.
  task automatic tick();
    @(posedge clk);
    #1;
    check("mon_count0", count0_o, m_count[0]);
    check("mon_match", {28'h0, match_o}, {28'h0, m_match});
    check("mon_irq", {31'h0, irq_o}, {31'h0, model_irq()});
    check("mon_ack", {31'h0, wbs_ack_o}, {31'h0, m_ack});
  endtask

  task automatic wb_access(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                           input logic [3:0] sel, output logic [31:0] rd,
                           output logic [31:0] rd16, output int lat);
    logic got;
    got = 1'b0;
    lat = 0;
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = we;
    wbs_adr_i = adr; wbs_dat_i = dat; wbs_sel_i = sel;
    for (int k = 0; k < 4 && !got; k++) begin
      tick();
      lat++;
      if (wbs_ack_o) got = 1'b1;
    end
    check("ack_timeout", {31'h0, got}, 32'h1);
    rd = wbs_dat_o;
    rd16 = dat16;
    if (!we) check("rd_vs_model", wbs_dat_o, m_rdat);
    $display("WB %s adr=0x%08h dat=0x%08h sel=%b rd=0x%08h lat=%0d",
             we ? "WR" : "RD", adr, dat, sel, wbs_dat_o, lat);
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
  endtask

  task automatic wr(input logic [31:0] adr, input logic [31:0] dat);
    logic [31:0] r, r16;
    int l;
    wb_access(1'b1, adr, dat, 4'hF, r, r16, l);
  endtask

  task automatic rd(input logic [31:0] adr, output logic [31:0] data);
    logic [31:0] r16;
    int l;
    wb_access(1'b0, adr, 32'h0, 4'hF, data, r16, l);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin : stim
    logic [31:0] v, v16;
    int lat;
    logic [31:0] exp_seq [5];
    logic [3:0]  exp_m1 [6];

    reset = 1'b1;
    wbs_cyc_i = 0; wbs_stb_i = 0; wbs_we_i = 0; wbs_sel_i = 0;
    wbs_adr_i = 0; wbs_dat_i = 0;
    la_freeze = 0; la_load_en = 0; la_load_val = 0;
    repeat (3) tick();
    check("rst_dat", wbs_dat_o, 32'h0);
    reset = 1'b0;

    // Ch0 up, periodic, LIMIT=3, irq_en
    wr(32'h08, 3);
    wr(32'h04, 0);
    wr(32'h00, 32'hD);
    check("up_start", count0_o, 32'h0);
    exp_seq = '{32'd1, 32'd2, 32'd3, 32'd0, 32'd1};
    for (int i = 0; i < 5; i++) begin
      tick();
      check("up_seq", count0_o, exp_seq[i]);
      check("up_match", {31'h0, match_o[0]}, (i == 3) ? 32'h1 : 32'h0);
    end
    check("up_irq", {31'h0, irq_o}, 32'h1);
    wr(32'h00, 32'h8);
    rd(32'h0C, v);
    check("up_status", v, 32'h1);
    check("up_irq_held", {31'h0, irq_o}, 32'h1);
    wr(32'h0C, 32'h1);
    tick();
    check("w1c_irq_low", {31'h0, irq_o}, 32'h0);

    // Ch1 down, one-shot from 2
    wr(32'h14, 2);
    wr(32'h10, 32'h3);
    exp_m1 = '{4'h0, 4'h0, 4'h1, 4'h0, 4'h0, 4'h0};
    for (int i = 0; i < 6; i++) begin
      tick();
      check("dn_match1", {31'h0, match_o[1]}, {28'h0, exp_m1[i]});
    end
    rd(32'h14, v);
    check("dn_count", v, 32'h0);
    rd(32'h10, v);
    check("dn_ctrl", v, 32'h2);

    // Byte-lane write to ch2 COUNT, plus 16-bit instance
    wb_access(1'b1, 32'h24, 32'hAABBCCDD, 4'b0010, v, v16, lat);
    wb_access(1'b0, 32'h24, 32'h0, 4'hF, v, v16, lat);
    check("lane_w32", v, 32'h0000CC00);
    check("lane_w16", v16, 32'h0000CC00);
    wb_access(1'b1, 32'h24, 32'hAABBCCDD, 4'hF, v, v16, lat);
    wb_access(1'b0, 32'h24, 32'h0, 4'hF, v, v16, lat);
    check("full_w32", v, 32'hAABBCCDD);
    check("full_w16", v16, 32'h0000CCDD);

    // W1C vs new match (LIMIT=0 up-periodic matches every cycle)
    wr(32'h08, 0);
    wr(32'h04, 0);
    wr(32'h00, 32'hD);
    tick(); tick();
    wr(32'h0C, 32'h1);
    check("w1c_vs_match_irq", {31'h0, irq_o}, 32'h1);
    rd(32'h0C, v);
    check("w1c_vs_match_st", v, 32'h1);
    wr(32'h00, 32'h0);
    wr(32'h0C, 32'h1);
    check("clr_irq", {31'h0, irq_o}, 32'h0);

    // WB write beats LA load
    la_load_val = 32'h20; la_load_en = 1'b1;
    tick();
    check("la_load", count0_o, 32'h20);
    wr(32'h04, 32'h10);
    la_load_en = 1'b0;
    check("wb_over_la", count0_o, 32'h10);
    tick();
    check("wb_over_la_hold", count0_o, 32'h10);

    // Freeze blocks counting and matches; writes still land
    wr(32'h08, 32'h10);
    la_freeze = 1'b1;
    wr(32'h00, 32'h5);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("frz_count", count0_o, 32'h10);
      check("frz_match", {28'h0, match_o}, 32'h0);
    end
    la_freeze = 1'b0;
    tick();
    check("unfrz_count", count0_o, 32'h0);
    check("unfrz_match", {31'h0, match_o[0]}, 32'h1);
    wr(32'h00, 32'h0);
    wr(32'h0C, 32'h1);

    // Nonexistent channel, and held strobe ack pattern
    tick();
    wb_access(1'b0, 32'hF4, 32'h0, 4'hF, v, v16, lat);
    check("ch15_data", v, 32'h0);
    check("ch15_lat", lat, 1);
    tick();
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b0; wbs_adr_i = 32'hF4;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("b2b_ack", {31'h0, wbs_ack_o}, (i % 2 == 0) ? 32'h1 : 32'h0);
      $display("B2B cycle=%0d ack=%0d dat=0x%08h", i, wbs_ack_o, wbs_dat_o);
    end
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
    tick();

    // Randomized traffic against the model
    for (int n = 0; n < 150; n++) begin
      logic [31:0] adr, dat;
      logic [3:0]  sel;
      int ch, rg;
      repeat ($urandom_range(0, 2)) tick();
      la_freeze   = ($urandom % 10) == 0;
      la_load_en  = ($urandom % 8) == 0;
      la_load_val = $urandom % 16;
      ch  = $urandom_range(0, 5);
      rg  = $urandom_range(0, 3);
      adr = {24'h0, 4'(ch), 2'(rg), 2'b00};
      dat = (rg == 0) ? ($urandom % 16) : (rg == 3) ? ($urandom % 2) : ($urandom % 12);
      sel = (($urandom % 4) == 0) ? 4'($urandom % 16) : 4'hF;
      wb_access(1'($urandom % 2), adr, dat, sel, v, v16, lat);
    end
    la_freeze = 0; la_load_en = 0;

    // Reset mid-count with an access pending
    wr(32'h08, 3);
    wr(32'h00, 32'hD);
    repeat (6) tick();
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b0; wbs_adr_i = 32'h04;
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      check("rst_ack", {31'h0, wbs_ack_o}, 32'h0);
      check("rst_match", {28'h0, match_o}, 32'h0);
      check("rst_irq", {31'h0, irq_o}, 32'h0);
      check("rst_count0", count0_o, 32'h0);
    end
    reset = 1'b0;
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
    tick();
    check("rst_no_late_ack", {31'h0, wbs_ack_o}, 32'h0);
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        rd({24'h0, 4'(c), 2'(r), 2'b00}, v);
        check("rst_reg", v, 32'h0);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog timeout observed=running expected=finished");
    $fatal(1, "watchdog");
  end

endmodule
